// File: rtl/bomb_controller_pkg.sv
// rtl/bomb_controller_pkg.sv - shared play-field geometry, colours, FSM encodings and tile helper
package bomb_controller_pkg;

    typedef logic [4:0] tile_t;

    localparam int          TILE_LOG2     = 5;
    localparam logic [9:0]  X_MIN         = 10'd144;
    localparam logic [9:0]  Y_MIN         = 10'd35;
    localparam tile_t       GRID_W        = 5'd20;
    localparam tile_t       GRID_H        = 5'd15;

    localparam logic [11:0] BOMB_RGB      = 12'h222;
    localparam logic [11:0] EXPLOSION_RGB = 12'hF80;

    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_ARMED      = 2'd1;
    localparam logic [1:0]  ST_EXPLODE    = 2'd2;

    // Unsigned 10-bit subtract: points left of/above the origin wrap to tiles past the grid edge.
    function automatic tile_t tile_of(input logic [9:0] p, input logic [9:0] origin);
        logic [9:0] d;
        d = p - origin;
        return d[TILE_LOG2 +: 5];
    endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// rtl/bomb_controller_if.sv - game-side inputs and pixel/status outputs of the bomb controller
interface bomb_controller_if;
    logic        C;
    logic        game_over;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic [9:0]  v_x;
    logic [9:0]  v_y;
    logic        bomb_on;
    logic [11:0] bomb_rgb;
    logic        explosion_on;
    logic [11:0] explosion_rgb;
    logic        exp_active;
    logic [4:0]  exp_tx;
    logic [4:0]  exp_ty;
    logic        bomberman_hit;

    modport master (
        output C, game_over, b_x, b_y, v_x, v_y,
        input  bomb_on, bomb_rgb, explosion_on, explosion_rgb,
               exp_active, exp_tx, exp_ty, bomberman_hit
    );

    modport slave (
        input  C, game_over, b_x, b_y, v_x, v_y,
        output bomb_on, bomb_rgb, explosion_on, explosion_rgb,
               exp_active, exp_tx, exp_ty, bomberman_hit
    );
endinterface

// File: rtl/bomb_controller_tile_cross_hit.sv
// rtl/bomb_controller_tile_cross_hit.sv - combinational test of a tile against a clipped explosion cross
module tile_cross_hit
    import bomb_controller_pkg::*;
#(
    parameter int EXP_LEN = 2
) (
    input  tile_t pt_x,
    input  tile_t pt_y,
    input  tile_t ctr_x,
    input  tile_t ctr_y,
    output logic  hit
);

    localparam logic signed [6:0] ARM = 7'(EXP_LEN);

    logic signed [6:0] dx;
    logic signed [6:0] dy;
    logic signed [6:0] adx;
    logic signed [6:0] ady;
    logic              in_field;

    // Signed differences on widened operands so the cross never wraps around a grid edge.
    always_comb begin
        dx       = $signed({2'b00, pt_x}) - $signed({2'b00, ctr_x});
        dy       = $signed({2'b00, pt_y}) - $signed({2'b00, ctr_y});
        adx      = (dx < 0) ? -dx : dx;
        ady      = (dy < 0) ? -dy : dy;
        in_field = (pt_x < GRID_W) && (pt_y < GRID_H);
        hit      = in_field && (((dy == 0) && (adx <= ARM)) || ((dx == 0) && (ady <= ARM)));
    end

endmodule

// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - single-bomb drop, fuse, blink and cross explosion with pixel/hit outputs
module bomb_controller
    import bomb_controller_pkg::*;
#(
    parameter int FUSE_CYCLES    = 300_000_000,
    parameter int EXPLODE_CYCLES = 50_000_000,
    parameter int BLINK_CYCLES   = 6_250_000,
    parameter int EXP_LEN        = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    bomb_controller_if.slave  bus
);

    localparam int CNT_MAX = (FUSE_CYCLES > EXPLODE_CYCLES) ? FUSE_CYCLES : EXPLODE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [CNT_W-1:0]   FUSE_LOAD   = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   EXP_LOAD    = CNT_W'(EXPLODE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLINK_START = CNT_W'(FUSE_CYCLES / 4);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_CYCLES - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               visible;
    tile_t              bomb_tx;
    tile_t              bomb_ty;

    tile_t drop_tx, drop_ty;
    tile_t pix_tx, pix_ty;
    logic  pix_in_cross;
    logic  man_in_cross;

    assign drop_tx = tile_of(bus.b_x + 10'd16, X_MIN);
    assign drop_ty = tile_of(bus.b_y + 10'd16, Y_MIN);
    assign pix_tx  = tile_of(bus.v_x, X_MIN);
    assign pix_ty  = tile_of(bus.v_y, Y_MIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            blink_cnt <= '0;
            visible   <= 1'b1;
            bomb_tx   <= '0;
            bomb_ty   <= '0;
        end else if (bus.game_over) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    blink_cnt <= '0;
                    visible   <= 1'b1;
                    if (bus.C) begin
                        state   <= ST_ARMED;
                        cnt     <= FUSE_LOAD;
                        bomb_tx <= drop_tx;
                        bomb_ty <= drop_ty;
                    end
                end
                ST_ARMED: begin
                    if (cnt == '0) begin
                        state <= ST_EXPLODE;
                        cnt   <= EXP_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Blinking only in the final quarter of the fuse.
                        if (cnt < BLINK_START) begin
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                visible   <= ~visible;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_EXPLODE: begin
                    blink_cnt <= '0;
                    visible   <= 1'b1;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tile_cross_hit #(.EXP_LEN(EXP_LEN)) u_pix_cross (
        .pt_x  (pix_tx),
        .pt_y  (pix_ty),
        .ctr_x (bomb_tx),
        .ctr_y (bomb_ty),
        .hit   (pix_in_cross)
    );

    tile_cross_hit #(.EXP_LEN(EXP_LEN)) u_man_cross (
        .pt_x  (drop_tx),
        .pt_y  (drop_ty),
        .ctr_x (bomb_tx),
        .ctr_y (bomb_ty),
        .hit   (man_in_cross)
    );

    assign bus.bomb_on       = (state == ST_ARMED) && visible &&
                               (pix_tx < GRID_W) && (pix_ty < GRID_H) &&
                               (pix_tx == bomb_tx) && (pix_ty == bomb_ty);
    assign bus.explosion_on  = (state == ST_EXPLODE) && pix_in_cross;
    assign bus.bomberman_hit = (state == ST_EXPLODE) && man_in_cross;
    assign bus.exp_active    = (state == ST_EXPLODE);
    assign bus.exp_tx        = bomb_tx;
    assign bus.exp_ty        = bomb_ty;
    assign bus.bomb_rgb      = BOMB_RGB;
    assign bus.explosion_rgb = EXPLOSION_RGB;

endmodule
